tx_burst_sched: RTL and testbench

TX_BURST_SCHED -- requirements
Module: tx_burst_sched

---
 rtl/tx_burst_sched.sv | 228 ++++++++++++++++++++++
 tb/tb_tx_burst_sched.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_burst_sched.sv
// tx_burst_sched: frames a TX burst as preamble, payload and guard I/Q phases through one output register.
// Optional statistics ports are compiled in with `define TX_BURST_SCHED_STATS_EN.
module tx_burst_sched #(
  parameter int                        DATA_W  = 16,
  parameter int                        LEN_W   = 12,
  parameter logic signed [DATA_W-1:0]  PRE_AMP = 16'sd8192
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic [LEN_W-1:0]         pre_len,
  input  logic [LEN_W-1:0]         pay_len,
  input  logic [LEN_W-1:0]         guard_len,
  input  logic signed [DATA_W-1:0] in_i,
  input  logic signed [DATA_W-1:0] in_q,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic signed [DATA_W-1:0] dout_i,
  output logic signed [DATA_W-1:0] dout_q,
  output logic                     dout_valid,
  input  logic                     dout_ready,
  output logic                     busy,
  output logic                     done,
  output logic                     underflow
`ifdef TX_BURST_SCHED_STATS_EN
  ,
  output logic [31:0]              sent_cnt,
  output logic [15:0]              uflow_cnt
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_PAY, S_GUARD, S_DRAIN} state_t;

  state_t                     state_q, state_d, next_phase;
  logic [LEN_W-1:0]           cnt_q, cnt_d;
  logic [LEN_W-1:0]           pre_len_q, pre_len_d;
  logic [LEN_W-1:0]           pay_len_q, pay_len_d;
  logic [LEN_W-1:0]           guard_len_q, guard_len_d;
  logic                       sign_q, sign_d;
  logic signed [DATA_W-1:0]   dout_i_q, dout_i_d;
  logic signed [DATA_W-1:0]   dout_q_q, dout_q_d;
  logic                       dout_valid_q, dout_valid_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic                       underflow_q, underflow_d;
  logic                       load_en;

  // First phase with a non-zero length among the remaining ones; DRAIN if none.
  function automatic state_t pick_phase(input logic [LEN_W-1:0] p,
                                        input logic [LEN_W-1:0] y,
                                        input logic [LEN_W-1:0] g);
    state_t s;
    s = S_DRAIN;
    if (g != '0) s = S_GUARD;
    if (y != '0) s = S_PAY;
    if (p != '0) s = S_PRE;
    return s;
  endfunction

  function automatic logic [LEN_W-1:0] phase_len(input state_t s,
                                                 input logic [LEN_W-1:0] p,
                                                 input logic [LEN_W-1:0] y,
                                                 input logic [LEN_W-1:0] g);
    logic [LEN_W-1:0] l;
    case (s)
      S_PRE:   l = p;
      S_PAY:   l = y;
      S_GUARD: l = g;
      default: l = '0;
    endcase
    return l;
  endfunction

  always_comb begin
    load_en      = !dout_valid_q || dout_ready;
    in_ready     = (state_q == S_PAY) && load_en;
    state_d      = state_q;
    next_phase   = S_DRAIN;
    cnt_d        = cnt_q;
    pre_len_d    = pre_len_q;
    pay_len_d    = pay_len_q;
    guard_len_d  = guard_len_q;
    sign_d       = sign_q;
    dout_i_d     = dout_i_q;
    dout_q_d     = dout_q_q;
    // A sample taken downstream empties the register unless a new one loads below.
    dout_valid_d = dout_valid_q && !dout_ready;
    done_d       = 1'b0;
    underflow_d  = 1'b0;

    if (abort && (state_q != S_IDLE)) begin
      state_d      = S_IDLE;
      cnt_d        = '0;
      dout_valid_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && !abort) begin
            pre_len_d   = pre_len;
            pay_len_d   = pay_len;
            guard_len_d = guard_len;
            next_phase  = pick_phase(pre_len, pay_len, guard_len);
            state_d     = next_phase;
            cnt_d       = phase_len(next_phase, pre_len, pay_len, guard_len);
            sign_d      = 1'b0;
          end
        end
        S_PRE: begin
          if (load_en) begin
            dout_i_d     = sign_q ? -PRE_AMP : PRE_AMP;
            dout_q_d     = '0;
            dout_valid_d = 1'b1;
            sign_d       = !sign_q;
            cnt_d        = cnt_q - LEN_W'(1);
            if (cnt_q == LEN_W'(1)) begin
              next_phase = pick_phase('0, pay_len_q, guard_len_q);
              state_d    = next_phase;
              cnt_d      = phase_len(next_phase, '0, pay_len_q, guard_len_q);
            end
          end
        end
        S_PAY: begin
          if (load_en) begin
            if (in_valid) begin
              dout_i_d     = in_i;
              dout_q_d     = in_q;
              dout_valid_d = 1'b1;
              cnt_d        = cnt_q - LEN_W'(1);
              if (cnt_q == LEN_W'(1)) begin
                next_phase = pick_phase('0, '0, guard_len_q);
                state_d    = next_phase;
                cnt_d      = phase_len(next_phase, '0, '0, guard_len_q);
              end
            end else begin
              // Starved: report it and leave a bubble rather than inventing a sample.
              underflow_d  = 1'b1;
              dout_valid_d = 1'b0;
            end
          end
        end
        S_GUARD: begin
          if (load_en) begin
            dout_i_d     = '0;
            dout_q_d     = '0;
            dout_valid_d = 1'b1;
            cnt_d        = cnt_q - LEN_W'(1);
            if (cnt_q == LEN_W'(1)) begin
              state_d = S_DRAIN;
              cnt_d   = '0;
            end
          end
        end
        S_DRAIN: begin
          if (load_en) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      pre_len_q    <= '0;
      pay_len_q    <= '0;
      guard_len_q  <= '0;
      sign_q       <= 1'b0;
      dout_i_q     <= '0;
      dout_q_q     <= '0;
      dout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pre_len_q    <= pre_len_d;
      pay_len_q    <= pay_len_d;
      guard_len_q  <= guard_len_d;
      sign_q       <= sign_d;
      dout_i_q     <= dout_i_d;
      dout_q_q     <= dout_q_d;
      dout_valid_q <= dout_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      underflow_q  <= underflow_d;
    end
  end

  assign dout_i     = dout_i_q;
  assign dout_q     = dout_q_q;
  assign dout_valid = dout_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign underflow  = underflow_q;

`ifdef TX_BURST_SCHED_STATS_EN
  logic [31:0] sent_cnt_q, sent_cnt_d;
  logic [15:0] uflow_cnt_q, uflow_cnt_d;

  always_comb begin
    sent_cnt_d  = sent_cnt_q + 32'(dout_valid_q && dout_ready);
    uflow_cnt_d = uflow_cnt_q;
    if (underflow_d && (uflow_cnt_q != 16'hFFFF)) uflow_cnt_d = uflow_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sent_cnt_q  <= '0;
      uflow_cnt_q <= '0;
    end else begin
      sent_cnt_q  <= sent_cnt_d;
      uflow_cnt_q <= uflow_cnt_d;
    end
  end

  assign sent_cnt  = sent_cnt_q;
  assign uflow_cnt = uflow_cnt_q;
`endif

endmodule

// File: tb/tb_tx_burst_sched.sv
// tb_tx_burst_sched: table-driven bursts, abort/reset sequences and randomized bursts
// checked against a phase-list model of the expected I/Q stream.
module tb_tx_burst_sched;
  localparam int LEN_W = 12;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic start = 1'b0, abort = 1'b0;
  logic [LEN_W-1:0] pre_len = '0, pay_len = '0, guard_len = '0;
  logic signed [15:0] in_i = '0, in_q = '0;
  logic in_valid = 1'b0, dout_ready = 1'b1;
  logic in_ready, dout_valid, busy, done, underflow;
  logic signed [15:0] dout_i, dout_q;
`ifdef TX_BURST_SCHED_STATS_EN
  logic [31:0] sent_cnt;
  logic [15:0] uflow_cnt;
  longint sent_before, uf_before;
`endif

  always #5 clk = ~clk;

  tx_burst_sched dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .pre_len(pre_len), .pay_len(pay_len), .guard_len(guard_len),
    .in_i(in_i), .in_q(in_q), .in_valid(in_valid), .in_ready(in_ready),
    .dout_i(dout_i), .dout_q(dout_q), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .busy(busy), .done(done), .underflow(underflow)
`ifdef TX_BURST_SCHED_STATS_EN
    , .sent_cnt(sent_cnt), .uflow_cnt(uflow_cnt)
`endif
  );

  int checks = 0, failures = 0;
  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];
  int done_cnt, done_idx, fv_idx, uf_cnt, in_cnt, starve_cnt, burst_base;
  int src_idx = 0;

  typedef struct {
    string name;
    int pre, pay, guard, dmode, vmode, exp_uf, exp_fv, exp_done;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic logic [15:0] src_i(input int k);
    return 16'(k * 37 + 100);
  endfunction
  function automatic logic [15:0] src_q(input int k);
    return 16'(-(k * 11) - 5);
  endfunction

  // Expected stream: alternating preamble, the next pay source samples, then zero guard.
  task automatic build_exp(input int pre, input int pay, input int guard, input int base);
    logic [15:0] amp;
    exp_q.delete();
    for (int k = 0; k < pre; k++) begin
      amp = 16'((k % 2 == 0) ? 8192 : -8192);
      exp_q.push_back({amp, 16'h0000});
    end
    for (int k = 0; k < pay; k++) exp_q.push_back({src_i(base + k), src_q(base + k)});
    for (int k = 0; k < guard; k++) exp_q.push_back(32'h0);
  endtask

  // dmode: 0 ready, 1 toggle, 2 random. vmode: 0 valid, 1 starve 3 cycles after first payload, 2 random.
  task automatic run_burst(input int pre, input int pay, input int guard,
                           input int dmode, input int vmode, input int abort_at);
    int n, starve_left, tot;
    logic last_in, pv, pr;
    logic [31:0] pd;
    got_q.delete();
    done_cnt = 0; done_idx = 0; fv_idx = 0; uf_cnt = 0; in_cnt = 0; starve_cnt = 0;
    starve_left = 3; last_in = 1'b0; pv = 1'b0; pr = 1'b0; pd = '0;
    tot = pre + pay + guard;
    burst_base = src_idx;
`ifdef TX_BURST_SCHED_STATS_EN
    sent_before = sent_cnt; uf_before = uflow_cnt;
`endif
    @(posedge clk); #1;
    start = 1'b1; abort = 1'b0;
    pre_len = LEN_W'(pre); pay_len = LEN_W'(pay); guard_len = LEN_W'(guard);
    in_i = src_i(src_idx); in_q = src_q(src_idx);
    in_valid = (vmode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
    dout_ready = (dmode == 2) ? ($urandom_range(0, 9) < 7) : 1'b1;
    for (n = 1; n <= 400; n++) begin
      @(negedge clk);
      if (pv && !pr) begin
        chk($sformatf("hold_valid@%0d", n), dout_valid, 1);
        chk($sformatf("hold_data@%0d", n), {dout_i, dout_q}, pd);
      end
      if (dout_valid && fv_idx == 0) fv_idx = n;
      if (dout_valid && dout_ready) got_q.push_back({dout_i, dout_q});
      last_in = in_valid && in_ready;
      if (last_in) in_cnt++;
      if (in_ready && !in_valid) starve_cnt++;
      if (underflow) uf_cnt++;
      if (done) begin
        done_cnt++;
        if (done_idx == 0) done_idx = n;
      end
      pv = dout_valid; pr = dout_ready; pd = {dout_i, dout_q};
      if (abort_at != 0 && n == abort_at + 2) begin
        chk("abort_busy", busy, 0);
        chk("abort_dout_valid", dout_valid, 0);
        chk("abort_in_ready", in_ready, 0);
      end
      if (abort_at != 0 && n == abort_at + 4) begin
        chk("abort_start_ignored", busy, 0);
        break;
      end
      if (done_idx != 0 && n == done_idx + 3) break;
      @(posedge clk); #1;
      abort = (abort_at != 0) && (n == abort_at);
      // Mid-burst start pulses must be ignored; only issued while samples remain untransferred.
      start = abort || ((vmode == 2) && (got_q.size() < tot) && ($urandom_range(0, 5) == 0));
      pre_len = LEN_W'($urandom); pay_len = LEN_W'($urandom); guard_len = LEN_W'($urandom);
      if (last_in) src_idx++;
      in_i = src_i(src_idx); in_q = src_q(src_idx);
      case (vmode)
        0: in_valid = 1'b1;
        1: begin
          if (in_cnt == 1 && starve_left > 0) begin
            in_valid = 1'b0;
            starve_left--;
          end else in_valid = 1'b1;
        end
        default: in_valid = ($urandom_range(0, 3) != 0);
      endcase
      case (dmode)
        0: dout_ready = 1'b1;
        1: dout_ready = !dout_ready;
        default: dout_ready = ($urandom_range(0, 9) < 7);
      endcase
    end
    start = 1'b0; abort = 1'b0; in_valid = 1'b0; dout_ready = 1'b1;
  endtask

  task automatic check_burst(input string tag, input int pre, input int pay, input int guard,
                             input int exp_uf, input int exp_fv, input int exp_done);
    int lim;
    build_exp(pre, pay, guard, burst_base);
    chk({tag, ".done_seen"}, (done_idx != 0), 1);
    chk({tag, ".xfers"}, got_q.size(), exp_q.size());
    lim = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < lim; i++) chk($sformatf("%s.sample[%0d]", tag, i), got_q[i], exp_q[i]);
    chk({tag, ".done_cnt"}, done_cnt, 1);
    chk({tag, ".in_cnt"}, in_cnt, pay);
    chk({tag, ".uflow"}, uf_cnt, (exp_uf < 0) ? starve_cnt : exp_uf);
    if (exp_fv >= 0) chk({tag, ".first_valid"}, fv_idx, exp_fv);
    if (exp_done > 0) chk({tag, ".done_at"}, done_idx, exp_done);
    chk({tag, ".busy_after"}, busy, 0);
`ifdef TX_BURST_SCHED_STATS_EN
    chk({tag, ".sent_cnt"}, longint'(sent_cnt) - sent_before, got_q.size());
    chk({tag, ".uflow_cnt"}, longint'(uflow_cnt) - uf_before, uf_cnt);
`endif
    $display("burst %s pre=%0d pay=%0d guard=%0d xfers=%0d uflow=%0d done_at=%0d",
             tag, pre, pay, guard, got_q.size(), uf_cnt, done_idx);
  endtask

  task automatic run_entry(input int idx);
    run_burst(tbl[idx].pre, tbl[idx].pay, tbl[idx].guard, tbl[idx].dmode, tbl[idx].vmode, 0);
    check_burst(tbl[idx].name, tbl[idx].pre, tbl[idx].pay, tbl[idx].guard,
                tbl[idx].exp_uf, tbl[idx].exp_fv, tbl[idx].exp_done);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //            name           pre pay grd dm vm uf  fv  done
    tbl[0] = '{"basic",          4,  3,  2,  0, 0, 0,  3,  12};
    tbl[1] = '{"backpressure",   4,  3,  2,  1, 0, 0, -1,  0};
    tbl[2] = '{"starve",         2,  3,  1,  0, 1, 3,  3,  12};
    tbl[3] = '{"pay_only",       0,  2,  0,  0, 0, 0,  3,  5};
    tbl[4] = '{"all_zero",       0,  0,  0,  0, 0, 0,  0,  3};
    tbl[5] = '{"guard_only",     0,  0,  3,  0, 0, 0,  3,  6};
    tbl[6] = '{"pre_one",        1,  0,  0,  0, 0, 0,  3,  4};
    tbl[7] = '{"pre_guard_bp",   3,  0,  2,  1, 0, 0, -1,  0};

    #1 reset_n = 1'b0;
    #2;
    chk("rst_dout_valid", dout_valid, 0);
    chk("rst_dout_i", dout_i, 0);
    chk("rst_dout_q", dout_q, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_underflow", underflow, 0);
    chk("rst_in_ready", in_ready, 0);
    @(posedge clk); #1 reset_n = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 8; i++) run_entry(i);

    // Abort while in GUARD, with start raised in the same cycle.
    run_burst(2, 2, 6, 0, 0, 7);
    chk("abort_no_done", done_cnt, 0);
    $display("burst abort pre=2 pay=2 guard=6 xfers=%0d done=%0d", got_q.size(), done_cnt);
    run_entry(0);

    // Asynchronous reset mid-PAY.
    @(posedge clk); #1;
    start = 1'b1; pre_len = 1; pay_len = 8; guard_len = 1;
    in_i = src_i(src_idx); in_q = src_q(src_idx); in_valid = 1'b1; dout_ready = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    chk("pre_reset_busy", busy, 1);
    chk("pre_reset_valid", dout_valid, 1);
    reset_n = 1'b0;
    #1;
    chk("async_rst_dout_valid", dout_valid, 0);
    chk("async_rst_dout_i", dout_i, 0);
    chk("async_rst_dout_q", dout_q, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_in_ready", in_ready, 0);
    chk("async_rst_done", done, 0);
    chk("async_rst_underflow", underflow, 0);
    in_valid = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("post_reset_idle[%0d]", k), busy, 0);
      chk($sformatf("post_reset_no_done[%0d]", k), done, 0);
    end
    $display("burst reset_mid_pay recovered busy=%0d", busy);
    run_entry(0);

    // Randomized bursts against the phase-list model.
    for (int r = 0; r < 20; r++) begin
      int p, y, g;
      p = $urandom_range(0, 5); y = $urandom_range(0, 5); g = $urandom_range(0, 5);
      run_burst(p, y, g, 2, 2, 0);
      check_burst($sformatf("rand%0d", r), p, y, g, -1, -1, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
